llr_bank_reader: RTL and testbench

LLR_BANK_READER -- requirements
Module: llr_bank_reader

---
 rtl/llr_bank_reader_pkg.sv | 11 +
 rtl/llr_bank_reader_store.sv | 21 ++
 rtl/llr_bank_reader.sv | 98 +++++++++
 tb/tb_llr_bank_reader.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/llr_bank_reader_pkg.sv
// Shared defaults, index width and FSM state encoding for the LLR bank reader.
package llr_bank_reader_pkg;
  localparam int WIDTH_DEF = 5;
  localparam int DEPTH_DEF = 8;
  localparam int IDX_W     = $clog2(DEPTH_DEF);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;
endpackage

// File: rtl/llr_bank_reader_store.sv
// Bank of DEPTH registered LLR words with an active-low parallel load.
module llr_store #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         load_n,
  input  logic [DEPTH*(WIDTH+1)-1:0]   load_data,
  output logic [WIDTH:0]               words [DEPTH]
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) words[i] <= '0;
    end else if (!load_n) begin
      for (int i = 0; i < DEPTH; i++) words[i] <= load_data[i*(WIDTH+1) +: (WIDTH+1)];
    end
  end

endmodule

// File: rtl/llr_bank_reader.sv
// Loads a bank of LLR words and streams them out in ascending or descending index order.
module llr_bank_reader
  import llr_bank_reader_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              load_n,
  input  logic [DEPTH*(WIDTH+1)-1:0]        load_data,
  input  logic                              reverse,
  output logic                              busy,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WIDTH:0]                    out_data,
  output logic [$clog2(DEPTH)-1:0]          out_index,
  output logic                              out_last,
  output logic                              done,
  output state_t                            state_dbg
);

  localparam int IW = $clog2(DEPTH);

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            rev_q, rev_d;
  logic            done_q, done_d;
  logic            store_load_n;
  logic            at_last;
  logic [WIDTH:0]  words [DEPTH];

  // Bank only accepts a load while idle, so a stream in flight never sees its data change.
  llr_store #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_store (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_n    (store_load_n),
    .load_data (load_data),
    .words     (words)
  );

  assign at_last = rev_q ? (idx_q == '0) : (idx_q == IW'(DEPTH - 1));

  // Handshake: a word moves on any edge with out_valid=1 and out_ready=1; while
  // out_ready=0 the presented word, index and last flag stay put.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rev_d        = rev_q;
    done_d       = 1'b0;
    store_load_n = 1'b1;
    case (state_q)
      IDLE: begin
        if (!load_n) begin
          store_load_n = 1'b0;
          rev_d        = reverse;
          idx_d        = reverse ? IW'(DEPTH - 1) : '0;
          state_d      = STREAM;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (at_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = rev_q ? idx_q - 1'b1 : idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rev_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rev_q   <= rev_d;
      done_q  <= done_d;
    end
  end

  // Index is held on the final transfer, so out_data keeps the last word while idle.
  assign out_data  = words[idx_q];
  assign out_index = idx_q;
  assign out_valid = (state_q == STREAM);
  assign busy      = (state_q == STREAM);
  assign out_last  = out_valid && at_last;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_llr_bank_reader.sv
// Directed bench for llr_bank_reader: ordering, backpressure, ignored loads, reset abort, back-to-back.
module tb_llr_bank_reader;
  import llr_bank_reader_pkg::*;

  localparam int W  = 5;
  localparam int D  = 8;
  localparam int IW = $clog2(D);

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 load_n;
  logic [D*(W+1)-1:0]   load_data;
  logic                 reverse;
  logic                 busy;
  logic                 out_valid;
  logic                 out_ready;
  logic [W:0]           out_data;
  logic [IW-1:0]        out_index;
  logic                 out_last;
  logic                 done;
  state_t               state_dbg;

  int errors = 0;
  int checks = 0;

  logic [D*(W+1)-1:0] base_image;
  logic [D*(W+1)-1:0] junk_image;

  llr_bank_reader #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_n    (load_n),
    .load_data (load_data),
    .reverse   (reverse),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .done      (done),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are read at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_bank(input logic [D*(W+1)-1:0] img, input logic rev);
    load_n    = 1'b0;
    load_data = img;
    reverse   = rev;
    tick();
    load_n    = 1'b1;
  endtask

  // Walks a full stream of the base image (words 3,5,..,17). Ends in the done cycle.
  task automatic expect_stream(input logic rev, input int stall_at, input int stall_n,
                               input logic inject);
    int idx;
    for (int k = 0; k < D; k++) begin
      idx = rev ? (D - 1 - k) : k;
      if (k == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          check("stall_valid", out_valid, 1);
          check("stall_data",  out_data, 3 + 2 * idx);
          check("stall_index", out_index, idx);
          check("stall_last",  out_last, (k == D - 1));
          tick();
        end
        out_ready = 1'b1;
      end
      check("valid", out_valid, 1);
      check("busy",  busy, 1);
      check("data",  out_data, 3 + 2 * idx);
      check("index", out_index, idx);
      check("last",  out_last, (k == D - 1));
      check("no_done", done, 0);
      if (inject && (k == 3 || k == D - 1)) begin
        load_n    = 1'b0;
        load_data = junk_image;
        reverse   = ~rev;
      end
      tick();
      load_n = 1'b1;
    end
    check("end_valid", out_valid, 0);
    check("end_busy",  busy, 0);
    check("done_pulse", done, 1);
  endtask

  initial begin
    for (int i = 0; i < D; i++) begin
      base_image[i*(W+1) +: (W+1)] = (W+1)'(3 + 2 * i);
      junk_image[i*(W+1) +: (W+1)] = 6'h3F;
    end
    reset_n   = 1'b0;
    load_n    = 1'b1;
    load_data = '0;
    reverse   = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_busy",  busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last",  out_last, 0);
    check("rst_done",  done, 0);
    check("rst_data",  out_data, 0);
    check("rst_index", out_index, 0);
    check("rst_state", state_dbg, IDLE);
    reset_n = 1'b1;
    tick();

    // Ascending stream, then idle holds the last word with done gone.
    load_bank(base_image, 1'b0);
    expect_stream(1'b0, -1, 0, 1'b0);
    tick();
    check("done_one_cycle", done, 0);
    check("idle_valid", out_valid, 0);
    check("idle_hold_data", out_data, 17);

    // Descending stream.
    load_bank(base_image, 1'b1);
    expect_stream(1'b1, -1, 0, 1'b0);
    tick();
    check("done_one_cycle_desc", done, 0);

    // Backpressure on word 2 for 3 cycles.
    load_bank(base_image, 1'b0);
    expect_stream(1'b0, 2, 3, 1'b0);
    tick();

    // Loads mid-stream and in the last-transfer cycle are ignored.
    load_bank(base_image, 1'b0);
    expect_stream(1'b0, -1, 0, 1'b1);
    tick();
    check("after_ignored_valid", out_valid, 0);
    check("after_ignored_data", out_data, 17);

    // Back-to-back: load in the done cycle; first word valid the following cycle.
    load_bank(base_image, 1'b0);
    expect_stream(1'b0, -1, 0, 1'b0);
    load_bank(base_image, 1'b1);
    check("b2b_done_cleared", done, 0);
    expect_stream(1'b1, -1, 0, 1'b0);
    tick();

    // Reset after the 4th word aborts with no done pulse.
    load_bank(base_image, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check("pre_rst_data", out_data, 3 + 2 * k);
      tick();
    end
    reset_n = 1'b0;
    load_n  = 1'b0;
    tick();
    reset_n = 1'b1;
    load_n  = 1'b1;
    check("abort_busy",  busy, 0);
    check("abort_valid", out_valid, 0);
    check("abort_data",  out_data, 0);
    check("abort_index", out_index, 0);
    check("abort_done",  done, 0);
    tick();
    check("abort_no_done_later", done, 0);
    load_bank(base_image, 1'b0);
    expect_stream(1'b0, -1, 0, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
